can_tx_stuff_sequencer: RTL and testbench

//   Transmit-side sequencer for the CAN bit-stuffing datapath. Accepts one

---
 rtl/can_tx_stuff_sequencer.sv | 149 ++++++++++++++
 tb/tb_can_tx_stuff_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_stuff_sequencer.sv
// CAN transmit bit-stuffing sequencer: serialises one frame MSB first, inserts
// complement stuff bits after runs of identical bits, then appends the recessive tail.
module can_tx_stuff_sequencer #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned LEN_W     = 7,
   parameter int unsigned STUFF_RUN = 5,
   parameter int unsigned TAIL_BITS = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              frame_valid,
   output logic              frame_ready,
   input  logic [DATA_W-1:0] frame_data,
   input  logic [LEN_W-1:0]  frame_len,
   input  logic              abort,
   output logic              tx_bit,
   output logic              tx_active,
   output logic              stuff_flag,
   output logic [5:0]        stuff_count,
   output logic              done
);

   localparam int unsigned RUN_W  = $clog2(STUFF_RUN + 1);
   localparam int unsigned TAIL_W = $clog2(TAIL_BITS + 1);
   localparam int unsigned CNT_W  = 6;

   typedef enum logic [1:0] {IDLE, DATA, STUFF, TAIL} state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  shreg, shreg_nxt;
   logic [LEN_W-1:0]   bits_left, bits_left_nxt;
   logic [RUN_W-1:0]   run, run_nxt;
   logic [TAIL_W-1:0]  tail_cnt, tail_cnt_nxt;
   logic [CNT_W-1:0]   stuff_count_nxt;
   logic               tx_bit_nxt, tx_active_nxt, stuff_flag_nxt, done_nxt, frame_ready_nxt;
   logic               data_bit;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         bits_left   <= '0;
         run         <= '0;
         tail_cnt    <= '0;
         stuff_count <= '0;
         tx_bit      <= 1'b1;
         tx_active   <= 1'b0;
         stuff_flag  <= 1'b0;
         done        <= 1'b0;
         frame_ready <= 1'b1;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         bits_left   <= bits_left_nxt;
         run         <= run_nxt;
         tail_cnt    <= tail_cnt_nxt;
         stuff_count <= stuff_count_nxt;
         tx_bit      <= tx_bit_nxt;
         tx_active   <= tx_active_nxt;
         stuff_flag  <= stuff_flag_nxt;
         done        <= done_nxt;
         frame_ready <= frame_ready_nxt;
      end
   end

   assign data_bit = shreg[DATA_W-1];

   // Next-state and next-output logic
   always_comb begin
      state_nxt       = state;
      shreg_nxt       = shreg;
      bits_left_nxt   = bits_left;
      run_nxt         = run;
      tail_cnt_nxt    = tail_cnt;
      stuff_count_nxt = stuff_count;
      tx_bit_nxt      = tx_bit;
      tx_active_nxt   = tx_active;
      stuff_flag_nxt  = stuff_flag;
      done_nxt        = 1'b0;

      case (state)
         IDLE: begin
            if (frame_valid) begin
               shreg_nxt       = frame_data;
               bits_left_nxt   = (frame_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : frame_len;
               stuff_count_nxt = '0;
               run_nxt         = '0;
               tail_cnt_nxt    = '0;
               state_nxt       = (frame_len == '0) ? TAIL : DATA;
            end
         end
         DATA: begin
            if (bit_en) begin
               tx_bit_nxt     = data_bit;
               tx_active_nxt  = 1'b1;
               stuff_flag_nxt = 1'b0;
               shreg_nxt      = {shreg[DATA_W-2:0], 1'b0};
               bits_left_nxt  = bits_left - LEN_W'(1);
               // run == 0 marks the first data bit, which always starts a fresh run
               run_nxt = (run != '0 && data_bit == tx_bit) ? run + RUN_W'(1) : RUN_W'(1);
               if (run_nxt == RUN_W'(STUFF_RUN))
                  state_nxt = STUFF;
               else if (bits_left == LEN_W'(1))
                  state_nxt = TAIL;
            end
         end
         STUFF: begin
            if (bit_en) begin
               tx_bit_nxt      = ~tx_bit;
               stuff_flag_nxt  = 1'b1;
               stuff_count_nxt = (stuff_count == '1) ? stuff_count : stuff_count + CNT_W'(1);
               run_nxt         = RUN_W'(1);
               state_nxt       = (bits_left == '0) ? TAIL : DATA;
            end
         end
         TAIL: begin
            if (bit_en) begin
               tx_bit_nxt     = 1'b1;
               stuff_flag_nxt = 1'b0;
               if (tail_cnt == TAIL_W'(TAIL_BITS)) begin
                  tx_active_nxt = 1'b0;
                  done_nxt      = 1'b1;
                  state_nxt     = IDLE;
               end else begin
                  tx_active_nxt = 1'b1;
                  tail_cnt_nxt  = tail_cnt + TAIL_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Abort wins over any strobe on the same edge; stuff_count keeps its pre-abort value
      if (abort && state != IDLE) begin
         state_nxt       = IDLE;
         tx_bit_nxt      = 1'b1;
         tx_active_nxt   = 1'b0;
         stuff_flag_nxt  = 1'b0;
         done_nxt        = 1'b0;
         run_nxt         = '0;
         stuff_count_nxt = stuff_count;
      end

      frame_ready_nxt = (state_nxt == IDLE);
   end

endmodule

// File: tb/tb_can_tx_stuff_sequencer.sv
// Scoreboard bench for can_tx_stuff_sequencer: a reference stuffing model fills
// an expected-bit queue per frame, popped and compared on every bit_en strobe.
module tb_can_tx_stuff_sequencer;

   localparam int unsigned DATA_W    = 64;
   localparam int unsigned LEN_W     = 7;
   localparam int unsigned STUFF_RUN = 5;
   localparam int unsigned TAIL_BITS = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              bit_en;
   logic              frame_valid;
   logic              frame_ready;
   logic [DATA_W-1:0] frame_data;
   logic [LEN_W-1:0]  frame_len;
   logic              abort;
   logic              tx_bit;
   logic              tx_active;
   logic              stuff_flag;
   logic [5:0]        stuff_count;
   logic              done;

   typedef struct packed {
      logic b;
      logic f;
   } exp_t;

   exp_t exp_q[$];
   int   exp_stuffs;
   int   total = 0;
   int   bad   = 0;

   can_tx_stuff_sequencer #(
      .DATA_W(DATA_W), .LEN_W(LEN_W), .STUFF_RUN(STUFF_RUN), .TAIL_BITS(TAIL_BITS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .frame_data(frame_data), .frame_len(frame_len),
      .abort(abort), .tx_bit(tx_bit), .tx_active(tx_active), .stuff_flag(stuff_flag),
      .stuff_count(stuff_count), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference stuffing model: data bits, stuff after each STUFF_RUN run, then tail
   task automatic build_expect(input logic [DATA_W-1:0] d, input int len);
      int   run;
      int   n;
      logic last;
      logic b;
      run  = 0;
      last = 1'b1;
      n    = (len > int'(DATA_W)) ? int'(DATA_W) : len;
      exp_stuffs = 0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         b    = d[DATA_W-1-i];
         run  = (run > 0 && b == last) ? run + 1 : 1;
         last = b;
         exp_q.push_back('{b: b, f: 1'b0});
         if (run == int'(STUFF_RUN)) begin
            exp_q.push_back('{b: ~b, f: 1'b1});
            last = ~b;
            run  = 1;
            exp_stuffs++;
         end
      end
      for (int i = 0; i < int'(TAIL_BITS); i++) exp_q.push_back('{b: 1'b1, f: 1'b0});
   endtask

   task automatic strobe();
      repeat (2) @(negedge clk);
      bit_en = 1'b1;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
   endtask

   task automatic accept(input logic [DATA_W-1:0] d, input int len, input bit hold,
                         input logic [DATA_W-1:0] d2, input int len2);
      @(negedge clk);
      check("ready_pre", 64'(frame_ready), 64'(1));
      frame_data  = d;
      frame_len   = LEN_W'(len);
      frame_valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold) begin
         frame_data = d2;
         frame_len  = LEN_W'(len2);
      end else begin
         frame_valid = 1'b0;
      end
      check("ready_post", 64'(frame_ready), 64'(0));
   endtask

   task automatic run_frame(input int want_cnt, input bit next_held);
      exp_t e;
      int   n;
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         strobe();
         n++;
         check($sformatf("bit%0d", n), 64'(tx_bit), 64'(e.b));
         check($sformatf("flag%0d", n), 64'(stuff_flag), 64'(e.f));
         check($sformatf("active%0d", n), 64'(tx_active), 64'(1));
         check($sformatf("nodone%0d", n), 64'(done), 64'(0));
      end
      strobe();
      check("done", 64'(done), 64'(1));
      check("active_end", 64'(tx_active), 64'(0));
      check("tx_idle", 64'(tx_bit), 64'(1));
      check("count", 64'(stuff_count), 64'(want_cnt));
      check("ready_end", 64'(frame_ready), 64'(1));
      if (!next_held) begin
         @(posedge clk);
         #1;
         check("done_pulse", 64'(done), 64'(0));
      end
   endtask

   task automatic frame(input logic [DATA_W-1:0] d, input int len, input int want_cnt);
      build_expect(d, len);
      accept(d, len, 1'b0, '0, 0);
      run_frame(want_cnt, 1'b0);
   endtask

   initial begin
      rst_n       = 1'b0;
      bit_en      = 1'b0;
      frame_valid = 1'b0;
      frame_data  = '0;
      frame_len   = '0;
      abort       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_bit", 64'(tx_bit), 64'(1));
      check("rst_active", 64'(tx_active), 64'(0));
      check("rst_ready", 64'(frame_ready), 64'(1));
      check("rst_flag", 64'(stuff_flag), 64'(0));
      check("rst_count", 64'(stuff_count), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      frame({8'hAA, 56'h0}, 8, 0);
      frame({8'hFF, 56'h0}, 8, 1);
      frame({32'hFF00FF00, 32'h0}, 32, 4);
      frame(64'h0, 5, 1);
      frame(64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
      // Oversized length clamps to the full register width
      build_expect(64'h0123_4567_89AB_CDEF, 100);
      accept(64'h0123_4567_89AB_CDEF, 100, 1'b0, '0, 0);
      run_frame(exp_stuffs, 1'b0);

      // Abort after three bits of 8'hF0
      build_expect({8'hF0, 56'h0}, 8);
      accept({8'hF0, 56'h0}, 8, 1'b0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         strobe();
         check($sformatf("abort_bit%0d", i), 64'(tx_bit), 64'(1));
      end
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_tx", 64'(tx_bit), 64'(1));
      check("abort_ready", 64'(frame_ready), 64'(1));
      check("abort_active", 64'(tx_active), 64'(0));
      check("abort_flag", 64'(stuff_flag), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      for (int i = 0; i < 3; i++) begin
         strobe();
         check($sformatf("post_abort_done%0d", i), 64'(done), 64'(0));
         check($sformatf("post_abort_active%0d", i), 64'(tx_active), 64'(0));
      end

      // frame_valid held through an active frame with different data; next frame taken after done
      build_expect({8'hAA, 56'h0}, 8);
      accept({8'hAA, 56'h0}, 8, 1'b1, {8'hFF, 56'h0}, 8);
      run_frame(0, 1'b1);
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      check("held_accept", 64'(frame_ready), 64'(0));
      build_expect({8'hFF, 56'h0}, 8);
      run_frame(1, 1'b0);

      // Asynchronous reset mid-frame
      accept({8'hFF, 56'h0}, 8, 1'b0, '0, 0);
      strobe();
      strobe();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_active", 64'(tx_active), 64'(0));
      check("arst_tx", 64'(tx_bit), 64'(1));
      check("arst_ready", 64'(frame_ready), 64'(1));
      check("arst_done", 64'(done), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      frame({8'hAA, 56'h0}, 8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
